clk_sel_ctrl: RTL and testbench
===============================

# clk_sel_ctrl

Switch-request sequencer that drives the `sel` input of the `glitch_free` clock multiplexer. It runs on a free-running reference clock and accepts switch requests through a valid/ready handshake. It toggles `sel` at most once per request, then blocks further requests for a settle window and a minimum dwell window, so the mux always finishes its two-clock handover before the next change. A one-cycle `done` pulse reports when the new clock can be relied on.

## Interface
- `SETTLE_CYC`, default 6: clk cycles allowed for the mux handover after `sel` changes; legal range 1..255.
- `DWELL_CYC`, default 16: minimum clk cycles a selection is held after settling; legal range 1..255.
- `SEL_RST`, default 1'b1: value of `sel` during and after reset.
- `clk` input, 1 bit: free-running reference clock; all logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req_valid` input, 1 bit: a switch request is present.
- `req_sel` input, 1 bit: requested selection (0 = clk0, 1 = clk1).
- `req_ready` output, 1 bit: the block can accept a request this cycle.
- `sel` output, 1 bit: registered selection to `glitch_free.sel`.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `done` output, 1 bit: single-cycle pulse when a request completes.
- `sw_cnt` output, 8 bits: number of completed real switches. Present only with `CLK_SEL_CNT_EN`.

## Operation
- **States.** IDLE, SETTLE and DWELL, plus one 8-bit down-counter `cnt`.
- **Handshake.** `req_ready` = (state == IDLE). A request is accepted when `req_valid & req_ready` is high at a rising edge. Requests are not queued. `req_valid` held while not ready has no effect until `req_ready` returns.
- **IDLE, real switch (`req_sel` ≠ `sel`).**
  - Register `sel <= req_sel`.
  - Load `cnt <= SETTLE_CYC-1`.
  - Go to SETTLE.
- **IDLE, redundant request (`req_sel` == `sel`).**
  - Accept the request; `sel` does not change.
  - `done` = 1 in the next cycle; state stays IDLE.
  - `sw_cnt` is not incremented.
- **SETTLE.**
  - `cnt` decrements each cycle.
  - When `cnt`==0: load `cnt <= DWELL_CYC-1`, go to DWELL, and `done` = 1 in the first DWELL cycle.
  - `sw_cnt` increments (saturating at 255) in that same edge.
- **DWELL.** `cnt` decrements each cycle; when `cnt`==0, go to IDLE.
- **Stability.** `sel` changes only on an IDLE acceptance or on reset. It never changes in SETTLE or DWELL.
- **Reset (including mid-operation).** In the cycle after `rst` is sampled high:
  - state = IDLE, `cnt` = 0, `sel` = `SEL_RST`;
  - `done` = 0, `busy` = 0, `req_ready` = 1, `sw_cnt` = 0.
  - An in-flight switch is abandoned with no `done` pulse.
  - `rst` overrides a simultaneous `req_valid`.

## Timing
- Cycle N is the handshake cycle of a real switch.
- **Cycle N+1:** `sel` shows the new value; `busy` = 1; `req_ready` = 0.
- **Cycles N+1 .. N+SETTLE_CYC:** SETTLE.
- **Cycle N+SETTLE_CYC+1:** first DWELL cycle; `done` = 1 for exactly this cycle.
- **Cycles N+SETTLE_CYC+1 .. N+SETTLE_CYC+DWELL_CYC:** DWELL.
- **Cycle N+SETTLE_CYC+DWELL_CYC+1:** IDLE; `req_ready` = 1.
- **Throughput.** Minimum spacing between real switches is SETTLE_CYC+DWELL_CYC+1 cycles.
- **Redundant request.** `done` pulses in cycle N+1; `req_ready` stays 1, so back-to-back redundant requests are accepted every cycle.
- **Registered outputs.** All outputs are registered; there is no combinational path from `req_*` to `sel` or `done`. `req_ready` is decoded from the state register only.

## Configuration
- **`CLK_SEL_CNT_EN` defined:**
  - The `sw_cnt` port and its 8-bit saturating register exist.
  - `sw_cnt` increments once per real switch, on the SETTLE→DWELL transition.
  - It holds at 255 and clears only on `rst`.
- **`CLK_SEL_CNT_EN` undefined:** the port and register are absent; all other behaviour is identical.

## Test plan
All scenarios use SETTLE_CYC=4, DWELL_CYC=8, SEL_RST=1.
- **Reset release.** Assert `rst` for 3 cycles, then release.
  - Required: `sel`=1, `req_ready`=1, `busy`=0, `done`=0, `sw_cnt`=0.
- **Single real switch.** `req_valid`=1, `req_sel`=0 accepted in cycle N.
  - `sel`=0 from N+1; `done` high only in N+5; `req_ready`=0 from N+1 to N+12 and 1 at N+13; `sw_cnt`=1.
- **Redundant request.** `req_sel`=1 while `sel`=1.
  - `done` pulses at N+1; `busy` never rises; `sw_cnt` unchanged.
- **Request blocked while busy.** `req_sel`=1 held from N+2 to N+20 after a switch to 0.
  - Second acceptance occurs exactly at N+13; `sel` returns to 1 at N+14; `done` pulses at N+18.
- **Reset mid-SETTLE.** Assert `rst` at N+2 of a switch to 0.
  - `sel`=1 at N+3; no `done` pulse; `req_ready`=1 at N+3; `sw_cnt`=0.
- **Counter saturation.** Perform 260 alternating real switches with `CLK_SEL_CNT_EN` defined.
  - `sw_cnt` reads 255 and stays at 255.

Source files
------------

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - sel sequencer for glitch_free mux with settle/dwell lockout
// Optional switch counter output sw_cnt is enabled by defining CLK_SEL_CNT_EN.
module clk_sel_ctrl #(
  parameter int unsigned SETTLE_CYC = 6,
  parameter int unsigned DWELL_CYC  = 16,
  parameter logic        SEL_RST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_sel,
  output logic       req_ready,
  output logic       sel,
  output logic       busy,
  output logic       done
`ifdef CLK_SEL_CNT_EN
  ,
  output logic [7:0] sw_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_e;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] DWELL_LD  = 8'(DWELL_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= SEL_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sel != sel_q) begin
            sel_d   = req_sel;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            // Already on the requested clock: acknowledge without touching the mux.
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = DWELL_LD;
          state_d = DWELL;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DWELL: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

`ifdef CLK_SEL_CNT_EN
  logic [7:0] sw_cnt_q, sw_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cnt_q <= 8'd0;
    end else begin
      sw_cnt_q <= sw_cnt_d;
    end
  end

  // Count only completed real switches, on the SETTLE->DWELL edge; saturate at 255.
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if (state_q == SETTLE && cnt_q == 8'd0 && sw_cnt_q != 8'hFF) begin
      sw_cnt_d = sw_cnt_q + 8'd1;
    end
  end

  assign sw_cnt = sw_cnt_q;
`endif

  assign sel       = sel_q;
  assign done      = done_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - directed self-checking bench for clk_sel_ctrl
// Saturation scenario and sw_cnt checks are built only with CLK_SEL_CNT_EN.
module tb_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic req_ready, sel, busy, done;
`ifdef CLK_SEL_CNT_EN
  logic [7:0] sw_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_sel_ctrl #(
    .SETTLE_CYC(4),
    .DWELL_CYC (8),
    .SEL_RST   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .sel      (sel),
    .busy     (busy),
    .done     (done)
`ifdef CLK_SEL_CNT_EN
    ,
    .sw_cnt   (sw_cnt)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1;
    req_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b want 1", sel); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef CLK_SEL_CNT_EN
    checks++;
    if (sw_cnt !== 8'd0) begin errors++; $display("FAIL reset_sw_cnt: got %0d want 0", sw_cnt); end
`endif
  endtask

  task automatic test_redundant();
    req_valid = 1'b1;
    req_sel = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== (k <= 3)) begin errors++; $display("FAIL redundant_done k=%0d: got %b want %b", k, done, (k <= 3)); end
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || sel !== 1'b1) begin
        errors++;
        $display("FAIL redundant_state k=%0d: busy=%b ready=%b sel=%b want 0 1 1", k, busy, req_ready, sel);
      end
      if (k == 3) req_valid = 1'b0;
    end
`ifdef CLK_SEL_CNT_EN
    checks++;
    if (sw_cnt !== 8'd0) begin errors++; $display("FAIL redundant_sw_cnt: got %0d want 0", sw_cnt); end
`endif
  endtask

  task automatic test_single_switch();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL switch_ready_n: got %b want 1", req_ready); end
    req_valid = 1'b1;
    req_sel = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      checks++;
      if (sel !== 1'b0) begin errors++; $display("FAIL switch_sel k=%0d: got %b want 0", k, sel); end
      checks++;
      if (done !== (k == 5)) begin errors++; $display("FAIL switch_done k=%0d: got %b want %b", k, done, (k == 5)); end
      checks++;
      if (req_ready !== (k == 13) || busy !== (k != 13)) begin
        errors++;
        $display("FAIL switch_ready k=%0d: ready=%b busy=%b want %b %b", k, req_ready, busy, (k == 13), (k != 13));
      end
    end
`ifdef CLK_SEL_CNT_EN
    checks++;
    if (sw_cnt !== 8'd1) begin errors++; $display("FAIL switch_sw_cnt: got %0d want 1", sw_cnt); end
`endif
  endtask

  task automatic test_blocked();
    logic exp_sel;
    apply_reset();
    req_valid = 1'b1;
    req_sel = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_sel = (k >= 14);
      checks++;
      if (sel !== exp_sel) begin errors++; $display("FAIL blocked_sel k=%0d: got %b want %b", k, sel, exp_sel); end
      checks++;
      if (done !== (k == 5 || k == 18)) begin
        errors++;
        $display("FAIL blocked_done k=%0d: got %b want %b", k, done, (k == 5 || k == 18));
      end
      checks++;
      if (req_ready !== (k == 13)) begin errors++; $display("FAIL blocked_ready k=%0d: got %b want %b", k, req_ready, (k == 13)); end
      if (k == 1) req_valid = 1'b0;
      if (k >= 1 && k < 20) begin req_valid = 1'b1; req_sel = 1'b1; end
      if (k == 1) req_valid = 1'b0;
      if (k == 20) req_valid = 1'b0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || sel !== 1'b1) begin
      errors++;
      $display("FAIL blocked_end: ready=%b sel=%b want 1 1", req_ready, sel);
    end
  endtask

  task automatic test_reset_mid_settle();
    apply_reset();
    req_valid = 1'b1;
    req_sel = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 2) begin
        checks++;
        if (sel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: sel=%b busy=%b want 0 1", sel, busy); end
        rst = 1'b1;
        req_valid = 1'b1;
        req_sel = 1'b0;
      end
      if (k == 3) begin
        rst = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_ready: ready=%b busy=%b want 1 0", req_ready, busy);
        end
      end
      if (k >= 3) begin
        checks++;
        if (sel !== 1'b1) begin errors++; $display("FAIL mid_sel k=%0d: got %b want 1", k, sel); end
      end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mid_done k=%0d: got %b want 0", k, done); end
    end
`ifdef CLK_SEL_CNT_EN
    checks++;
    if (sw_cnt !== 8'd0) begin errors++; $display("FAIL mid_sw_cnt: got %0d want 0", sw_cnt); end
`endif
  endtask

`ifdef CLK_SEL_CNT_EN
  task automatic test_saturation();
    logic want_sel;
    int   wait_cyc;
    apply_reset();
    want_sel = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      want_sel = ~want_sel;
      req_valid = 1'b1;
      req_sel = want_sel;
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc = 0;
      while (req_ready !== 1'b1 && wait_cyc < 40) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (wait_cyc >= 40) begin
        checks++;
        errors++;
        $display("FAIL sat_timeout i=%0d: ready=%b want 1", i, req_ready);
      end
      if (i == 100 || i == 255 || i == 260) begin
        checks++;
        if (sw_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++;
          $display("FAIL sat_sw_cnt i=%0d: got %0d want %0d", i, sw_cnt, (i > 255) ? 255 : i);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_redundant();
    test_single_switch();
    test_blocked();
    test_reset_mid_settle();
`ifdef CLK_SEL_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
